// File: rtl/bridge_pkg.sv
// bridge_pkg: address map and state encodings shared by the mem_io_bridge slice.
package bridge_pkg;
    localparam logic [17:0] MMIO_UART = 18'h30000;
    localparam logic [17:0] MMIO_CNT  = 18'h30004;
    localparam logic [17:0] RAM_TOP   = 18'h20000;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_RX, SEL_CNT} rsel_t;
endpackage

// File: rtl/bridge_tx_fifo.sv
// bridge_tx_fifo: synchronous byte FIFO with occupancy count and registered almost-full flag.
module bridge_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int SLACK = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_req,
    output logic                     valid,
    output logic [7:0]               data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW:0] AF_CNT   = CW'(DEPTH - SLACK);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push_ok, pop;

    assign valid     = count != '0;
    assign data      = mem[rd_ptr];
    assign pop       = valid && pop_req;
    assign push_ok   = push && count != FULL_CNT;
    assign count_nxt = count + CW'(push_ok) - CW'(pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push_ok);
            rd_ptr      <= rd_ptr + AW'(pop);
            count       <= count_nxt;
            almost_full <= count_nxt >= AF_CNT;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: cpu byte-bus decoder steering to 128KB RAM or UART/counter/stop MMIO.
// Define BRIDGE_ADDR_CHECK_EN to flag and suppress accesses outside RAM and 0x30000..0x30007.
module mem_io_bridge
    import bridge_pkg::*;
#(
    parameter int TX_DEPTH   = 16,
    parameter int FULL_SLACK = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_done,
    output logic        bad_addr
);
    logic [17:0] addr;
    logic        mmio, uart_hit, cnt_hit, bad, rd_ok, wr_ok, stop_wr, push, unused_hi;
    logic [7:0]  push_data, rd_q, cnt_byte;
    logic [31:0] counter, snap;
    logic [$clog2(TX_DEPTH):0] fifo_count;
    rsel_t       sel;
    state_t      state;

    assign addr      = cpu_a[17:0];
    assign unused_hi = ^cpu_a[31:18];
    assign mmio      = addr[17:16] == 2'b11;
    assign uart_hit  = addr == MMIO_UART;
    assign cnt_hit   = addr[17:2] == MMIO_CNT[17:2];
`ifdef BRIDGE_ADDR_CHECK_EN
    assign bad = rdy_in && (mmio ? addr[17:3] != MMIO_UART[17:3] : addr >= RAM_TOP);
`else
    assign bad = 1'b0;
`endif
    assign wr_ok     = rdy_in && !bad && cpu_wr;
    assign rd_ok     = rdy_in && !bad && !cpu_wr;
    assign ram_a     = cpu_a[16:0];
    assign ram_din   = cpu_dout;
    assign ram_wr    = wr_ok && !mmio;
    assign rx_pop    = !rst_in && rd_ok && uart_hit && rx_valid;
    assign stop_wr   = wr_ok && addr == MMIO_CNT && state == RUN;
    assign push      = stop_wr || (wr_ok && uart_hit && state == RUN && cpu_dout != 8'h00);
    assign push_data = stop_wr ? 8'h00 : cpu_dout;
    // byte 0 returns the live count and latches it so bytes 1..3 come from the same sample
    assign cnt_byte  = addr[1:0] == 2'b00 ? counter[7:0] : 8'(snap >> {addr[1:0], 3'b000});
    assign cpu_din   = sel == SEL_RAM ? ram_dout : rd_q;

    bridge_tx_fifo #(.DEPTH(TX_DEPTH), .SLACK(FULL_SLACK)) u_tx_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push        (push),
        .push_data   (push_data),
        .pop_req     (tx_ready),
        .valid       (tx_valid),
        .data        (tx_data),
        .count       (fifo_count),
        .almost_full (io_buffer_full)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            counter   <= '0;
            snap      <= '0;
            sel       <= SEL_NONE;
            rd_q      <= 8'h00;
            state     <= RUN;
            prog_done <= 1'b0;
            bad_addr  <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            sel     <= !rd_ok ? SEL_NONE : !mmio ? SEL_RAM : uart_hit ? SEL_RX : cnt_hit ? SEL_CNT : SEL_NONE;
            rd_q    <= rx_pop ? rx_data : (rd_ok && cnt_hit) ? cnt_byte : 8'h00;
            if (rd_ok && cnt_hit && addr[1:0] == 2'b00) snap <= counter;
            if (stop_wr) state <= DRAIN;
            else if (state == DRAIN && fifo_count == '0) begin
                state     <= HALT;
                prog_done <= 1'b1;
            end
            if (bad) bad_addr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: randomized and directed stimulus checked every cycle against a queue-based bridge model.
module tb_mem_io_bridge;
    localparam int DEPTH = 16;
    localparam int SLACK = 2;
`ifdef BRIDGE_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, cpu_wr, rx_valid, tx_ready;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout, rx_data, ram_dout;
    logic [7:0]  cpu_din, ram_din, tx_data;
    logic [16:0] ram_a;
    logic        io_buffer_full, ram_wr, rx_pop, tx_valid, prog_done, bad_addr;

    int checks = 0;
    int errors = 0;

    bit   [7:0]  env_ram [0:131071];
    bit   [7:0]  m_ram   [0:131071];
    logic [7:0]  q[$];
    logic [7:0]  got[$];
    logic [31:0] m_cnt = 0, m_snap = 0;
    logic [7:0]  m_din = 0;
    bit          m_full, m_done, m_bad, m_stop, m_live;

    mem_io_bridge #(.TX_DEPTH(DEPTH), .FULL_SLACK(SLACK)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .ram_a(ram_a),
        .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_pop(rx_pop), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .prog_done(prog_done), .bad_addr(bad_addr)
    );

    always #5 clk_in = ~clk_in;

    // external RAM with one-cycle read latency
    always @(posedge clk_in) begin
        if (ram_wr) env_ram[ram_a] <= ram_din;
        ram_dout <= env_ram[ram_a];
    end

    task automatic chk(input string n, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, got_v, exp_v, $time);
        end
    endtask

    always @(negedge clk_in) begin : compare
        logic [17:0] a;
        logic        mm, b, ok, stop_now, do_push;
        logic [7:0]  nd, pb;
        int          n;
        #2;
        a  = cpu_a[17:0];
        mm = a[17:16] == 2'b11;
        b  = CHK && rdy_in && (mm ? (a < 18'h30000 || a > 18'h30007) : a >= 18'h20000);
        ok = rdy_in && !b;
        if (m_live) begin
            chk("ram_a", 32'(ram_a), 32'(a[16:0]));
            chk("ram_din", 32'(ram_din), 32'(cpu_dout));
            chk("ram_wr", 32'(ram_wr), 32'(ok && cpu_wr && !mm));
            chk("rx_pop", 32'(rx_pop), 32'(ok && !cpu_wr && a == 18'h30000 && rx_valid && !rst_in));
            chk("cpu_din", 32'(cpu_din), 32'(m_din));
            chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
            chk("io_buffer_full", 32'(io_buffer_full), 32'(m_full));
            chk("prog_done", 32'(prog_done), 32'(m_done));
            chk("bad_addr", 32'(bad_addr), 32'(m_bad));
        end
        if (rst_in) begin
            q.delete();
            m_cnt = 0; m_snap = 0; m_din = 0;
            m_full = 0; m_done = 0; m_bad = 0; m_stop = 0; m_live = 1;
        end else if (m_live) begin
            nd = 8'h00; pb = 8'h00; do_push = 0; stop_now = 0; n = q.size();
            if (ok && !cpu_wr) begin
                if (!mm) nd = m_ram[a[16:0]];
                else if (a == 18'h30000) nd = rx_valid ? rx_data : 8'h00;
                else if (a >= 18'h30004 && a <= 18'h30007) begin
                    if (a[1:0] == 2'b00) begin
                        nd = m_cnt[7:0];
                        m_snap = m_cnt;
                    end else nd = 8'(m_snap >> (8 * a[1:0]));
                end
            end
            if (ok && cpu_wr) begin
                if (!mm) m_ram[a[16:0]] = cpu_dout;
                else if (!m_stop && a == 18'h30000 && cpu_dout != 8'h00) begin
                    do_push = 1; pb = cpu_dout;
                end else if (!m_stop && a == 18'h30004) begin
                    do_push = 1; stop_now = 1;
                end
            end
            if (m_stop && n == 0) m_done = 1;
            if (n > 0 && tx_ready) void'(q.pop_front());
            if (do_push && n < DEPTH) q.push_back(pb);
            m_stop = m_stop | stop_now;
            m_full = (DEPTH - q.size()) <= SLACK;
            m_bad  = m_bad | b;
            m_din  = nd;
            m_cnt  = m_cnt + 1;
        end
    end

    task automatic drive(input logic r, input logic [17:0] a, input logic w, input logic [7:0] d, input logic t);
        @(negedge clk_in);
        rst_in   = 1'b0;
        rdy_in   = r;
        cpu_a    = {14'($urandom), a};
        cpu_wr   = w;
        cpu_dout = d;
        tx_ready = t;
        rx_valid = 1'($urandom);
        rx_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b0; cpu_wr = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [17:0] ra;
        logic [7:0]  exp_tx [4];
        bit          drained;
        exp_tx = '{8'h11, 8'h22, 8'h33, 8'h00};
        rst_in = 1'b1; rdy_in = 1'b0; cpu_a = '0; cpu_wr = 1'b0; cpu_dout = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        do_reset();
        #3;
        chk("reset_cpu_din", 32'(cpu_din), 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_full", 32'(io_buffer_full), 32'h0);
        chk("reset_prog_done", 32'(prog_done), 32'h0);

        drive(1, 18'h30000, 1, 8'h41, 1);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
        chk("tx_first_valid", 32'(tx_valid), 32'h1);
        chk("tx_first_data", 32'(tx_data), 32'h41);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
        chk("tx_first_popped", 32'(tx_valid), 32'h0);

        for (int i = 0; i < 13; i++) drive(1, 18'h30000, 1, 8'(i + 1), 0);
        drive(1, 18'h30000, 1, 8'h0E, 0); #3;
        chk("full_at_13", 32'(io_buffer_full), 32'h0);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
        chk("full_at_14", 32'(io_buffer_full), 32'h1);
        drive(0, 18'h0, 0, 8'h0, 0); #3;
        chk("full_after_pop", 32'(io_buffer_full), 32'h0);
        repeat (20) drive(0, 18'h0, 0, 8'h0, 1);

        drive(1, 18'h00100, 1, 8'h5A, 1);
        drive(1, 18'h00100, 0, 8'h00, 1);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
        chk("ram_readback", 32'(cpu_din), 32'h5A);

        drive(0, 18'h30000, 1, 8'h33, 0);
        drive(0, 18'h0, 0, 8'h0, 0); #3;
        chk("rdy_low_no_push", 32'(tx_valid), 32'h0);

        do_reset();
        for (int i = 0; i < 2000 && m_cnt != 32'h1F2; i++) drive(0, 18'h0, 0, 8'h0, 1);
        drive(1, 18'h30004, 0, 8'h0, 1);
        drive(1, 18'h30005, 0, 8'h0, 1); #3;
        chk("cnt_byte0", 32'(cpu_din), 32'hF3);
        drive(1, 18'h30006, 0, 8'h0, 1); #3;
        chk("cnt_byte1", 32'(cpu_din), 32'h01);
        drive(1, 18'h30007, 0, 8'h0, 1); #3;
        chk("cnt_byte2", 32'(cpu_din), 32'h00);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
        chk("cnt_byte3", 32'(cpu_din), 32'h00);

        drive(1, 18'h05000, 1, 8'h77, 1);
        drive(1, 18'h25000, 0, 8'h00, 1);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
`ifdef BRIDGE_ADDR_CHECK_EN
        chk("bad_read_data", 32'(cpu_din), 32'h00);
        chk("bad_read_flag", 32'(bad_addr), 32'h1);
`else
        chk("alias_read_data", 32'(cpu_din), 32'h77);
        chk("alias_read_flag", 32'(bad_addr), 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            rst_in = $urandom_range(0, 599) == 0;
            rdy_in = !rst_in && $urandom_range(0, 7) != 0;
            cpu_wr = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ra = 18'h00100 + 18'($urandom_range(0, 7));
                4, 5:       ra = 18'h30000;
                6, 7:       ra = 18'h30004 + 18'($urandom_range(0, 3));
                8:          ra = 18'h25000;
                default:    ra = 18'h30010;
            endcase
            if (ra[17:2] == 16'hC001) cpu_wr = 1'b0;
            cpu_a    = {14'($urandom), ra};
            cpu_dout = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
            tx_ready = $urandom_range(0, 2) == 0;
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
        end

        do_reset();
        drive(1, 18'h30000, 1, 8'h11, 0);
        drive(1, 18'h30000, 1, 8'h22, 0);
        drive(1, 18'h30000, 1, 8'h33, 0);
        drive(1, 18'h30004, 1, 8'h99, 0);
        drained = 0;
        got.delete();
        for (int i = 0; i < 20 && !drained; i++) begin
            drive(0, 18'h0, 0, 8'h0, 1); #3;
            if (tx_valid) got.push_back(tx_data);
            else drained = 1;
        end
        chk("stop_drained", 32'(drained), 32'h1);
        chk("stop_done_at_drain", 32'(prog_done), 32'h0);
        drive(0, 18'h0, 0, 8'h0, 1); #3;
        chk("stop_done_after", 32'(prog_done), 32'h1);
        chk("stop_tx_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("stop_tx_byte", 32'(got[i]), 32'(exp_tx[i]));
        drive(1, 18'h30000, 1, 8'h55, 0);
        drive(0, 18'h0, 0, 8'h0, 0); #3;
        chk("halt_ignores_push", 32'(tx_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
